// File: rtl/adder8_pkg.sv
// Shared types and arithmetic helpers for the adder8 responder.
// ADDER8_RESP_OVF_EN adds a signed-overflow bit to every stored response.
package adder8_pkg;

  localparam int ADDER_W   = 8;
  // Tags are zero-padded to this width in storage; TAG_W must not exceed it.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic [ADDER_W-1:0] a;
    logic [ADDER_W-1:0] b;
    logic               cin;
  } adder8_req_t;

  typedef struct packed {
    logic [ADDER_W-1:0]   sum;
    logic                 cout;
    logic [TAG_MAX_W-1:0] tag;
`ifdef ADDER8_RESP_OVF_EN
    logic                 ovf;
`endif
  } adder8_rsp_t;

  function automatic logic [ADDER_W:0] adder8_calc(input adder8_req_t req);
    return {1'b0, req.a} + {1'b0, req.b} + {{ADDER_W{1'b0}}, req.cin};
  endfunction

`ifdef ADDER8_RESP_OVF_EN
  // Signed overflow: operands share a sign bit that the result does not.
  function automatic logic adder8_ovf(input adder8_req_t req,
                                      input logic [ADDER_W-1:0] sum);
    return (req.a[ADDER_W-1] == req.b[ADDER_W-1]) &&
           (sum[ADDER_W-1] != req.a[ADDER_W-1]);
  endfunction
`endif

  function automatic adder8_rsp_t adder8_make_rsp(input adder8_req_t req,
                                                  input logic [TAG_MAX_W-1:0] tag);
    adder8_rsp_t      rsp;
    logic [ADDER_W:0] res;
    res      = adder8_calc(req);
    rsp.sum  = res[ADDER_W-1:0];
    rsp.cout = res[ADDER_W];
    rsp.tag  = tag;
`ifdef ADDER8_RESP_OVF_EN
    rsp.ovf  = adder8_ovf(req, res[ADDER_W-1:0]);
`endif
    return rsp;
  endfunction

endpackage

// File: rtl/adder8_rsp_fifo.sv
// Synchronous response FIFO of adder8_rsp_t with occupancy and next-occupancy outputs.
// Storage width follows ADDER8_RESP_OVF_EN through the package struct.
module adder8_rsp_fifo
  import adder8_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  adder8_rsp_t       push_data,
  input  logic              pop,
  output adder8_rsp_t       head,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level,
  output logic [LVL_W-1:0]  level_nxt
);

  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

  adder8_rsp_t      mem_q [DEPTH];
  adder8_rsp_t      mem_d [DEPTH];
  adder8_rsp_t      last_q, last_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == DEPTH_LVL);
  assign empty = (level_q == '0);

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // While empty the head keeps presenting the most recently popped entry.
  assign head      = empty ? last_q : mem_q[rd_ptr_q];
  assign level     = level_q;
  assign level_nxt = level_d;

endmodule

// File: rtl/adder8_resp.sv
// Sequential 8-bit adder responder: valid/ready requests in, queued in-order responses out.
// Define ADDER8_RESP_OVF_EN to add the per-response signed-overflow output rsp_ovf.
module adder8_resp
  import adder8_pkg::*;
#(
  parameter  int RSP_DEPTH = 4,
  parameter  int TAG_W     = 4,
  localparam int LVL_W     = $clog2(RSP_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDER_W-1:0]   req_a,
  input  logic [ADDER_W-1:0]   req_b,
  input  logic                 req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ADDER_W-1:0]   rsp_sum,
  output logic                 rsp_cout,
  output logic [TAG_W-1:0]     rsp_tag,
`ifdef ADDER8_RESP_OVF_EN
  output logic                 rsp_ovf,
`endif
  output logic [LVL_W-1:0]     level
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // req_ready is registered from the next-cycle occupancy, so a full FIFO
  // refuses requests even while a pop frees a slot that same cycle.
  // rsp_valid and its payload stay stable until popped.

  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(RSP_DEPTH);

  logic [TAG_W-1:0] tag_q, tag_d;
  logic             req_ready_q, req_ready_d;
  logic             req_fire, rsp_fire;
  adder8_req_t      req;
  adder8_rsp_t      push_rsp, head_rsp;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level, fifo_level_nxt;
  logic             tag_pad_unused;

  always_comb begin
    req.a       = req_a;
    req.b       = req_b;
    req.cin     = req_cin;
    req_fire    = req_valid && req_ready_q && !fifo_full;
    rsp_fire    = rsp_ready && !fifo_empty;
    tag_d       = tag_q;
    if (req_fire) tag_d = tag_q + TAG_W'(1);
    push_rsp    = adder8_make_rsp(req, TAG_MAX_W'(tag_q));
    req_ready_d = (fifo_level_nxt < DEPTH_LVL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q       <= '0;
      req_ready_q <= 1'b0;
    end else begin
      tag_q       <= tag_d;
      req_ready_q <= req_ready_d;
    end
  end

  adder8_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (req_fire),
    .push_data (push_rsp),
    .pop       (rsp_fire),
    .head      (head_rsp),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .level_nxt (fifo_level_nxt)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = !fifo_empty;
  assign rsp_sum   = head_rsp.sum;
  assign rsp_cout  = head_rsp.cout;
  assign rsp_tag   = head_rsp.tag[TAG_W-1:0];
`ifdef ADDER8_RESP_OVF_EN
  assign rsp_ovf   = head_rsp.ovf;
`endif
  assign level     = fifo_level;

  // Stored tags are zero-padded; the padding bits are never observed.
  assign tag_pad_unused = ^head_rsp.tag;

endmodule

// File: tb/tb_adder8_resp.sv
// Directed bench for adder8_resp; checks rsp_ovf too when ADDER8_RESP_OVF_EN is defined.
`timescale 1ns/1ps
module tb_adder8_resp;

  localparam int RSP_DEPTH = 4;
  localparam int TAG_W     = 4;
  localparam int LVL_W     = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_a;
  logic [7:0]       req_b;
  logic             req_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_sum;
  logic             rsp_cout;
  logic [TAG_W-1:0] rsp_tag;
`ifdef ADDER8_RESP_OVF_EN
  logic             rsp_ovf;
`endif
  logic [LVL_W-1:0] level;

  int n_assert = 0;
  int n_fail   = 0;

  // Back-pressure vectors with hand-computed sums.
  logic [7:0] bp_a [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
  logic [7:0] bp_b [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
  logic       bp_c [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] bp_s [5] = '{8'h11, 8'h23, 8'h33, 8'h45, 8'h55};

  always #5 clk = ~clk;

  adder8_resp #(
    .RSP_DEPTH (RSP_DEPTH),
    .TAG_W     (TAG_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_tag   (rsp_tag),
`ifdef ADDER8_RESP_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .level     (level)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [7:0] a, input logic [7:0] b, input logic c);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_cin   = c;
  endtask

  task automatic check_head(input string name, input logic [7:0] s, input logic c,
                            input logic [TAG_W-1:0] t);
    check({name, "_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "_sum"},   32'(rsp_sum),   32'(s));
    check({name, "_cout"},  32'(rsp_cout),  32'(c));
    check({name, "_tag"},   32'(rsp_tag),   32'(t));
  endtask

  // One request into an empty FIFO, seen one edge later, then popped.
  task automatic send_one(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [7:0] s, input logic co,
                          input logic [TAG_W-1:0] t, input logic ovf);
    rsp_ready = 1'b1;
    drive_req(a, b, c);
    step();
    check_head(name, s, co, t);
    check({name, "_level"}, 32'(level), 32'd1);
`ifdef ADDER8_RESP_OVF_EN
    check({name, "_ovf"}, 32'(rsp_ovf), 32'(ovf));
`else
    if (ovf === 1'bx) $display("note: %s has unknown overflow expectation", name);
`endif
    req_valid = 1'b0;
    step();
    check({name, "_popped_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_popped_level"}, 32'(level), 32'd0);
  endtask

  task automatic do_reset(input string name);
    rstn = 1'b0;
    #1;
    check({name, "_valid"},     32'(rsp_valid), 32'd0);
    check({name, "_level"},     32'(level),     32'd0);
    check({name, "_req_ready"}, 32'(req_ready), 32'd0);
    check({name, "_sum"},       32'(rsp_sum),   32'd0);
    check({name, "_cout"},      32'(rsp_cout),  32'd0);
    check({name, "_tag"},       32'(rsp_tag),   32'd0);
`ifdef ADDER8_RESP_OVF_EN
    check({name, "_ovf"},       32'(rsp_ovf),   32'd0);
`endif
    step();
    rstn = 1'b1;
    step();
    check({name, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [7:0]       sa, sb;
    logic             sc;
    logic [8:0]       res;
    logic [TAG_W-1:0] t;

    rstn      = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 1'b0;
    rsp_ready = 1'b0;

    // Power-on reset.
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_valid",     32'(rsp_valid), 32'd0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_sum",       32'(rsp_sum),   32'd0);
    check("rst_cout",      32'(rsp_cout),  32'd0);
    check("rst_tag",       32'(rsp_tag),   32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check("ready_before_edge", 32'(req_ready), 32'd0);
    step();
    check("ready_after_edge", 32'(req_ready), 32'd1);

    // Single requests, carry wrap and overflow vectors.
    send_one("basic",  8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 4'd0, 1'b0);
    send_one("wrap1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4'd1, 1'b0);
    send_one("wrap2",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 4'd2, 1'b0);
    send_one("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 4'd3, 1'b1);
    send_one("ovf_neg", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 4'd4, 1'b1);
    send_one("no_ovf", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 4'd5, 1'b0);

    do_reset("reset2");

    // Back-pressure: fill, stall the fifth, free one slot, then drain.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(bp_a[i], bp_b[i], bp_c[i]);
      step();
      check("bp_fill_level", 32'(level), 32'(i + 1));
    end
    check("bp_full_ready", 32'(req_ready), 32'd0);
    drive_req(bp_a[4], bp_b[4], bp_c[4]);
    step();
    check("bp_stall_level", 32'(level),     32'd4);
    check("bp_stall_ready", 32'(req_ready), 32'd0);
    check_head("bp_head0", bp_s[0], 1'b0, 4'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_pulse_level", 32'(level),     32'd3);
    check("bp_pulse_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("bp_fifth_level", 32'(level),     32'd4);
    check("bp_fifth_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check_head("bp_drain", bp_s[i], 1'b0, TAG_W'(i));
      step();
    end
    check("bp_empty_valid", 32'(rsp_valid), 32'd0);
    check("bp_empty_level", 32'(level),     32'd0);

    // Streaming: one push and one pop every edge; tags wrap 15 -> 0.
    t = 4'd5;
    for (int i = 0; i < 20; i++) begin
      sa  = 8'(i * 37 + 5);
      sb  = 8'(255 - i * 13);
      sc  = 1'(i);
      res = {1'b0, sa} + {1'b0, sb} + {8'd0, sc};
      drive_req(sa, sb, sc);
      step();
      check("stream_level", 32'(level), 32'd1);
      check_head("stream", res[7:0], res[8], t);
`ifdef ADDER8_RESP_OVF_EN
      check("stream_ovf", 32'(rsp_ovf),
            32'((sa[7] == sb[7]) && (res[7] != sa[7])));
`endif
      t = t + 4'd1;
    end
    req_valid = 1'b0;
    step();
    check("stream_end_level", 32'(level),     32'd0);
    check("stream_end_valid", 32'(rsp_valid), 32'd0);

    // Reset with three responses queued flushes them and the tag counter.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(8'(i), 8'h01, 1'b0);
      step();
    end
    req_valid = 1'b0;
    check("midrst_pre_level", 32'(level), 32'd3);
    check_head("midrst_pre_head", 8'h01, 1'b0, 4'd9);
    do_reset("midrst");
    send_one("after_rst", 8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
